// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: ALU operations,
// opcode/funct constants, datapath mux selects and the FSM state type.
package mips_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        ADDI_EXEC = 4'd8,
        ADDI_WB   = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        TRAP      = 4'd12
    } state_t;

endpackage

// File: rtl/mips_mc_ctrl_alu_decoder.sv
// Maps an R-type funct field to an ALU operation; valid is low for any
// funct the datapath does not implement.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] alu_op,
    output logic       valid
);

    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (func)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: FSM sequencing fetch/decode/execute/writeback
// with a handshaked memory port and a retired-instruction counter.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           op,
    input  logic [5:0]           func,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 iord,
    output logic                 ir_en,
    output logic                 pc_en,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           alu_op,
    output logic                 reg_write_en,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired
);

    state_t     state;
    state_t     next_state;
    logic       retire;
    logic [2:0] r_alu_op;
    logic       func_valid;

    alu_decoder u_alu_decoder (
        .func   (func),
        .alu_op (r_alu_op),
        .valid  (func_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                retired <= retired + CNT_WIDTH'(1);
            end
        end
    end

    // Memory states hold until mem_ready; retire marks the last cycle of an instruction.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            FETCH:     if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_RTYPE:     next_state = func_valid ? R_EXEC : TRAP;
                    OP_ADDI:      next_state = ADDI_EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    default:      next_state = TRAP;
                endcase
            end
            MEM_ADDR:  next_state = (op == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:    if (mem_ready) next_state = MEM_WB;
            MEM_WB: begin
                next_state = FETCH;
                retire     = 1'b1;
            end
            MEM_WR: begin
                if (mem_ready) begin
                    next_state = FETCH;
                    retire     = 1'b1;
                end
            end
            R_EXEC:    next_state = R_WB;
            R_WB, ADDI_WB, BRANCH, JUMP: begin
                next_state = FETCH;
                retire     = 1'b1;
            end
            ADDI_EXEC: next_state = ADDI_WB;
            TRAP:      next_state = TRAP;
            default:   next_state = TRAP;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        pc_src       = PC_SRC_ALU;
        alu_src_a    = 1'b0;
        alu_src_b    = SRC_B_REG;
        alu_op       = ALU_ADD;
        reg_write_en = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        illegal      = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_en     = mem_ready;
                pc_en     = mem_ready;
            end
            DECODE:    alu_src_b = SRC_B_IMM_SH2;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEM_WB: begin
                reg_write_en = 1'b1;
                mem_to_reg   = 1'b1;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = r_alu_op;
            end
            R_WB: begin
                reg_write_en = 1'b1;
                reg_dst      = 1'b1;
            end
            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            ADDI_WB:   reg_write_en = 1'b1;
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_en     = zero;
            end
            JUMP: begin
                pc_src = PC_SRC_JUMP;
                pc_en  = 1'b1;
            end
            TRAP:      illegal = 1'b1;
            default:   illegal = 1'b1;
        endcase
        // Reset forces every enable low immediately, abandoning any memory request.
        if (rst) begin
            mem_req      = 1'b0;
            ir_en        = 1'b0;
            pc_en        = 1'b0;
            reg_write_en = 1'b0;
            illegal      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: directed instruction sequences push
// expected per-cycle outputs; a negedge monitor pops and compares them.
module tb_mips_mc_ctrl;
    import mips_pkg::*;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        iord;
        logic        ir_en;
        logic        pc_en;
        logic [1:0]  pc_src;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [2:0]  alu_op;
        logic        reg_write_en;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        illegal;
        logic [31:0] retired;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op = '0;
    logic [5:0]  func = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_en, pc_en;
    logic [1:0]  pc_src, alu_src_b;
    logic        alu_src_a;
    logic [2:0]  alu_op;
    logic        reg_write_en, reg_dst, mem_to_reg, illegal;
    logic [31:0] retired;

    logic        mem_req4, mem_we4, iord4, ir_en4, pc_en4;
    logic [1:0]  pc_src4, alu_src_b4;
    logic        alu_src_a4;
    logic [2:0]  alu_op4;
    logic        reg_write_en4, reg_dst4, mem_to_reg4, illegal4;
    logic [3:0]  retired4;

    outs_t       act;
    outs_t       exp_q[$];
    string       name_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_retired = '0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_en(ir_en), .pc_en(pc_en),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write_en(reg_write_en), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .retired(retired)
    );

    // Narrow-counter instance on the same inputs, used to observe wrap-around.
    mips_mc_ctrl #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req4), .mem_we(mem_we4), .iord(iord4), .ir_en(ir_en4), .pc_en(pc_en4),
        .pc_src(pc_src4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
        .reg_write_en(reg_write_en4), .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4),
        .illegal(illegal4), .retired(retired4)
    );

    assign act = {mem_req, mem_we, iord, ir_en, pc_en, pc_src, alu_src_a, alu_src_b,
                  alu_op, reg_write_en, reg_dst, mem_to_reg, illegal, retired};

    function automatic outs_t expect_state(input state_t st, input logic rdy,
                                           input logic zf, input logic [2:0] rop);
        outs_t e;
        e = '0;
        e.alu_op  = 3'b010;
        e.retired = exp_retired;
        case (st)
            FETCH:     begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_en = rdy; e.pc_en = rdy; end
            DECODE:    e.alu_src_b = 2'b11;
            MEM_ADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            MEM_RD:    begin e.mem_req = 1; e.iord = 1; end
            MEM_WB:    begin e.reg_write_en = 1; e.mem_to_reg = 1; end
            MEM_WR:    begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; end
            R_EXEC:    begin e.alu_src_a = 1; e.alu_op = rop; end
            R_WB:      begin e.reg_write_en = 1; e.reg_dst = 1; end
            ADDI_EXEC: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            ADDI_WB:   e.reg_write_en = 1;
            BRANCH:    begin e.alu_src_a = 1; e.alu_op = 3'b110; e.pc_src = 2'b01; e.pc_en = zf; end
            JUMP:      begin e.pc_src = 2'b10; e.pc_en = 1; end
            default:   e.illegal = 1;
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input outs_t e);
        tests_run++;
        if (act !== e || retired4 !== e.retired[3:0]) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h (retired4 %h), expected %h (retired4 %h)",
                     name, act, retired4, e, e.retired[3:0]);
        end
    endtask

    task automatic checkReset(input string name);
        tests_run++;
        if ({mem_req, ir_en, pc_en, reg_write_en, illegal} !== 5'b0 ||
            retired !== exp_retired || retired4 !== exp_retired[3:0]) begin
            tests_failed++;
            $display("[TB] FAIL %s: enables %b retired %0d/%0d, expected enables 00000 retired %0d",
                     name, {mem_req, ir_en, pc_en, reg_write_en, illegal}, retired, retired4,
                     exp_retired);
        end
    endtask

    // One clock cycle of stimulus; the expected outputs for that cycle go to the scoreboard.
    task automatic applyStimulus(input string name, input logic [5:0] op_v, input logic [5:0] func_v,
                                 input logic zf, input logic rdy, input state_t st,
                                 input logic [2:0] rop);
        @(posedge clk);
        #1;
        op = op_v;
        func = func_v;
        zero = zf;
        mem_ready = rdy;
        exp_q.push_back(expect_state(st, rdy, zf, rop));
        name_q.push_back(name);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(name_q.pop_front(), exp_q.pop_front());
        end
    end

    task automatic do_rtype(input string name, input logic [5:0] fn, input logic [2:0] rop);
        applyStimulus({name, "_fetch"}, OP_RTYPE, fn, 0, 1, FETCH, 0);
        applyStimulus({name, "_decode"}, OP_RTYPE, fn, 0, 1, DECODE, 0);
        applyStimulus({name, "_exec"}, OP_RTYPE, fn, 0, 1, R_EXEC, rop);
        applyStimulus({name, "_wb"}, OP_RTYPE, fn, 0, 1, R_WB, 0);
        exp_retired++;
    endtask

    task automatic do_jump(input string name);
        applyStimulus({name, "_fetch"}, OP_J, 0, 0, 1, FETCH, 0);
        applyStimulus({name, "_decode"}, OP_J, 0, 0, 1, DECODE, 0);
        applyStimulus({name, "_jump"}, OP_J, 0, 0, 1, JUMP, 0);
        exp_retired++;
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        #1;
        rst = 1'b1;
        exp_retired = '0;
        #1;
        checkReset(name);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkReset("reset_hold");
        rst = 1'b0;

        applyStimulus("fetch_wait", OP_RTYPE, FN_ADD, 0, 0, FETCH, 0);
        do_rtype("add", FN_ADD, 3'b010);
        do_rtype("sub", FN_SUB, 3'b110);
        do_rtype("and", FN_AND, 3'b000);
        do_rtype("or", FN_OR, 3'b001);
        do_rtype("slt", FN_SLT, 3'b111);

        applyStimulus("lw_fetch", OP_LW, 0, 0, 1, FETCH, 0);
        applyStimulus("lw_decode", OP_LW, 0, 0, 1, DECODE, 0);
        applyStimulus("lw_addr", OP_LW, 0, 0, 1, MEM_ADDR, 0);
        for (int i = 0; i < 3; i++) applyStimulus("lw_rd_wait", OP_LW, 0, 0, 0, MEM_RD, 0);
        applyStimulus("lw_rd_done", OP_LW, 0, 0, 1, MEM_RD, 0);
        applyStimulus("lw_wb", OP_LW, 0, 0, 1, MEM_WB, 0);
        exp_retired++;

        applyStimulus("sw_fetch", OP_SW, 0, 0, 1, FETCH, 0);
        applyStimulus("sw_decode", OP_SW, 0, 0, 1, DECODE, 0);
        applyStimulus("sw_addr", OP_SW, 0, 0, 1, MEM_ADDR, 0);
        applyStimulus("sw_wr_wait", OP_SW, 0, 0, 0, MEM_WR, 0);
        applyStimulus("sw_wr_done", OP_SW, 0, 0, 1, MEM_WR, 0);
        exp_retired++;

        applyStimulus("addi_fetch", OP_ADDI, 0, 0, 1, FETCH, 0);
        applyStimulus("addi_decode", OP_ADDI, 0, 0, 1, DECODE, 0);
        applyStimulus("addi_exec", OP_ADDI, 0, 0, 1, ADDI_EXEC, 0);
        applyStimulus("addi_wb", OP_ADDI, 0, 0, 1, ADDI_WB, 0);
        exp_retired++;

        for (int z = 0; z < 2; z++) begin
            applyStimulus("beq_fetch", OP_BEQ, 0, 0, 1, FETCH, 0);
            applyStimulus("beq_decode", OP_BEQ, 0, 0, 1, DECODE, 0);
            applyStimulus(z == 0 ? "beq_not_taken" : "beq_taken", OP_BEQ, 0, 1'(z), 1, BRANCH, 0);
            exp_retired++;
        end

        applyStimulus("sw2_fetch", OP_SW, 0, 0, 1, FETCH, 0);
        applyStimulus("sw2_decode", OP_SW, 0, 0, 1, DECODE, 0);
        applyStimulus("sw2_addr", OP_SW, 0, 0, 1, MEM_ADDR, 0);
        applyStimulus("sw2_wr_wait", OP_SW, 0, 0, 0, MEM_WR, 0);
        applyStimulus("sw2_wr_wait", OP_SW, 0, 0, 0, MEM_WR, 0);
        pulse_reset("sw_mid_reset");
        applyStimulus("after_reset_fetch", OP_J, 0, 0, 0, FETCH, 0);

        for (int i = 0; i < 16; i++) do_jump("jump");
        applyStimulus("jump_wrapped", OP_J, 0, 0, 0, FETCH, 0);

        applyStimulus("bad_op_fetch", 6'b111111, 0, 1, 1, FETCH, 0);
        applyStimulus("bad_op_decode", 6'b111111, 0, 1, 1, DECODE, 0);
        for (int i = 0; i < 10; i++) applyStimulus("bad_op_trap", 6'b111111, 0, 1, 1, TRAP, 0);
        pulse_reset("trap_reset");
        applyStimulus("trap_exit_fetch", OP_RTYPE, 6'b000000, 0, 0, FETCH, 0);

        applyStimulus("bad_fn_fetch", OP_RTYPE, 6'b000000, 0, 1, FETCH, 0);
        applyStimulus("bad_fn_decode", OP_RTYPE, 6'b000000, 0, 1, DECODE, 0);
        applyStimulus("bad_fn_trap", OP_RTYPE, 6'b000000, 0, 1, TRAP, 0);

        @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 CNT_WIDTH, 32, width of the retired-instruction counter.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  opcode field from the instruction register (IR).
REQ-005 func  input  6  funct field from the IR.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completes the current request this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 mem_we  output  1  access type qualifying mem_req: 1 write, 0 read.
REQ-010 iord  output  1  memory address select: 0 PC, 1 ALU-out register.
REQ-011 ir_en  output  1  IR load enable.
REQ-012 pc_en  output  1  PC load enable.
REQ-013 pc_src  output  2  PC source: 00 ALU result, 01 ALU-out register, 10 jump target.
REQ-014 alu_src_a  output  1  ALU A source: 0 PC, 1 register A.
REQ-015 alu_src_b  output  2  ALU B source: 00 register B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
REQ-016 alu_op  output  3  ALU operation select.
REQ-017 reg_write_en / reg_dst / mem_to_reg  output  1 each  register write enable; destination (0 rt, 1 rd); write-data source (0 ALU-out, 1 memory data register).
REQ-018 illegal  output  1  unsupported op or func decoded.
REQ-019 retired  output  CNT_WIDTH  count of completed instructions.

Function
REQ-020 The FSM SHALL have states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP and TRAP.
REQ-021 Any output not listed for a state SHALL be 0, except alu_op, which defaults to ADD.
REQ-022 FETCH: mem_req=1, iord=0, a=0, b=01, ADD, pc_src=00, ir_en=pc_en=mem_ready; hold until mem_ready=1, then go to DECODE.
REQ-023 DECODE: a=0, b=11, ADD (branch target precompute).
REQ-024 DECODE next state: lw 100011 / sw 101011 -> MEM_ADDR; R-type 000000 with supported func -> R_EXEC; addi 001000 -> ADDI_EXEC; beq 000100 -> BRANCH; j 000010 -> JUMP; anything else -> TRAP.
REQ-025 Supported funct values SHALL be add 100000, sub 100010, and 100100, or 100101 and slt 101010.
REQ-026 MEM_ADDR: a=1, b=10, ADD; next state MEM_RD for lw, MEM_WR for sw.
REQ-027 MEM_RD: mem_req=1, mem_we=0, iord=1; hold until mem_ready, then go to MEM_WB.
REQ-028 MEM_WB: reg_write_en=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-029 MEM_WR: mem_req=1, mem_we=1, iord=1; hold until mem_ready, then go to FETCH.
REQ-030 R_EXEC: a=1, b=00, alu_op decoded from func; next state R_WB.
REQ-031 R_WB: reg_write_en=1, reg_dst=1; next state FETCH.
REQ-032 ADDI_EXEC: a=1, b=10, ADD; next state ADDI_WB.
REQ-033 ADDI_WB: reg_write_en=1, reg_dst=0; next state FETCH.
REQ-034 BRANCH: a=1, b=00, SUB, pc_src=01, pc_en=zero; next state FETCH.
REQ-035 JUMP: pc_src=10, pc_en=1; next state FETCH.
REQ-036 TRAP: illegal=1 and every enable 0; remain in TRAP until reset.
REQ-037 Only ir_en and pc_en in FETCH and pc_en in BRANCH SHALL be combinational from inputs; all other outputs SHALL decode from state alone.
REQ-038 mem_req, once raised, SHALL stay high until mem_ready is sampled high.
REQ-039 mem_we and iord SHALL be stable while mem_req is high.
REQ-040 mem_ready while mem_req=0 SHALL be ignored.
REQ-041 retired SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, ADDI_WB, BRANCH or JUMP, and SHALL wrap from all-ones to 0.

Reset
REQ-042 rst SHALL asynchronously set state=FETCH and retired=0.
REQ-043 While rst is high, mem_req, ir_en, pc_en, reg_write_en and illegal SHALL be 0.
REQ-044 rst mid-access SHALL abandon the request; the first cycle after release is FETCH with mem_req=1.

Structure
REQ-045 Package mips_pkg SHALL hold: alu_op encodings (AND 000, OR 001, ADD 010, SUB 110, SLT 111); opcode and funct constants; pc_src and alu_src_b encodings; state enum.
REQ-046 Sub-module alu_decoder SHALL map func to alu_op plus a valid bit.

Verification
REQ-047 add (op 000000, func 100000), mem_ready=1 -> FETCH, DECODE, R_EXEC (alu_op 010), R_WB (reg_write_en=1, reg_dst=1); 4 cycles; retired 0->1.
REQ-048 lw, mem_ready low 3 cycles in MEM_RD -> mem_req=1 and iord=1 for 4 cycles, then MEM_WB with mem_to_reg=1; 8 cycles total.
REQ-049 beq with zero=0, then zero=1 -> BRANCH shows pc_src=01, alu_op=110, and pc_en 0, then 1.
REQ-050 op 111111 -> TRAP, illegal=1 held 10 cycles, retired unchanged; rst returns to FETCH with illegal=0.
REQ-051 rst pulsed during MEM_WR wait -> mem_req drops without a clock edge; after release FETCH, retired=0.
REQ-052 CNT_WIDTH=4, 16 consecutive j -> retired returns to 0.
